// File: rtl/xy_scan_if.sv
// Beat stream from the raster-scan generator: one beat covers LANES adjacent pixels.
// The master presents a beat and holds it until out_ready accepts it.
interface xy_scan_if #(
    parameter int X_BITS = 10,
    parameter int Y_BITS = 10,
    parameter int LANES  = 1
);
    logic              out_valid;
    logic              out_ready;
    logic [X_BITS-1:0] out_x;
    logic [Y_BITS-1:0] out_y;
    logic [LANES-1:0]  lane_mask;
    logic              eol;
    logic              eof;

    modport master (
        output out_valid, out_x, out_y, lane_mask, eol, eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_x, out_y, lane_mask, eol, eof,
        output out_ready
    );
endinterface

// File: rtl/xy_scan_gen.sv
// Raster x/y scan generator: walks a (max_x+1) x (max_y+1) frame LANES pixels per beat,
// optionally repeating frames, with stall, abort and completed-frame counting.
module xy_scan_gen #(
    parameter int X_BITS    = 10,
    parameter int Y_BITS    = 10,
    parameter int LANES     = 1,
    parameter int FCNT_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 continuous,
    input  logic [X_BITS-1:0]    max_x,
    input  logic [Y_BITS-1:0]    max_y,
    xy_scan_if.master            out_if,
    output logic                 busy,
    output logic                 done,
    output logic [FCNT_BITS-1:0] frame_cnt
);

    localparam int XW = X_BITS + 1;
    // One extra bit so LANES == 2**X_BITS and x + LANES past max_x never wrap.
    localparam logic [XW-1:0] LANES_W = XW'(LANES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [X_BITS-1:0]     x_q, x_d;
    logic [Y_BITS-1:0]     y_q, y_d;
    logic [X_BITS-1:0]     max_x_q, max_x_d;
    logic [Y_BITS-1:0]     max_y_q, max_y_d;
    logic                  cont_q, cont_d;
    logic [FCNT_BITS-1:0]  fcnt_q, fcnt_d;
    logic                  done_q, done_d;

    logic [XW-1:0]         x_ext, max_x_ext, x_sum;
    logic [LANES-1:0]      lane_mask;
    logic                  eol, eof, fire;

    always_comb begin
        x_ext     = {1'b0, x_q};
        max_x_ext = {1'b0, max_x_q};
        x_sum     = x_ext + LANES_W;
        eol       = x_sum > max_x_ext;
        eof       = eol && (y_q == max_y_q);
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = (x_ext + XW'(i)) <= max_x_ext;
        end
    end

    assign busy              = (state_q == RUN);
    assign fire              = busy && out_if.out_ready;
    assign done              = done_q;
    assign frame_cnt         = fcnt_q;
    assign out_if.out_valid  = busy;
    assign out_if.out_x      = x_q;
    assign out_if.out_y      = y_q;
    assign out_if.lane_mask  = lane_mask;
    assign out_if.eol        = eol;
    assign out_if.eof        = eof;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves a variable unassigned (no latch).
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        max_x_d = max_x_q;
        max_y_d = max_y_q;
        cont_d  = cont_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    max_x_d = max_x;
                    max_y_d = max_y;
                    cont_d  = continuous;
                    x_d     = '0;
                    y_d     = '0;
                    fcnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (fire) begin
                    if (!eol) begin
                        x_d = x_sum[X_BITS-1:0];
                    end else if (!eof) begin
                        x_d = '0;
                        y_d = y_q + Y_BITS'(1);
                    end else begin
                        x_d    = '0;
                        y_d    = '0;
                        fcnt_d = fcnt_q + FCNT_BITS'(1);
                        if (!cont_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            max_x_q <= '0;
            max_y_q <= '0;
            cont_q  <= 1'b0;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            max_x_q <= max_x_d;
            max_y_q <= max_y_d;
            cont_q  <= cont_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_xy_scan_gen.sv
// Directed bench for xy_scan_gen: a LANES=1 and a LANES=4 instance share stimulus;
// a per-cycle vector table covers the basic scan with a stall, hand sequences the corners.
module tb_xy_scan_gen;

    logic       clk = 1'b0;
    logic       rst, start, abort, cont, ready;
    logic [9:0] max_x, max_y;
    logic       busy1, done1, busy4, done4;
    logic [7:0] fcnt1, fcnt4;
    int         checks = 0;
    int         errors = 0;

    xy_scan_if #(.X_BITS(10), .Y_BITS(10), .LANES(1)) if1 ();
    xy_scan_if #(.X_BITS(10), .Y_BITS(10), .LANES(4)) if4 ();
    assign if1.out_ready = ready;
    assign if4.out_ready = ready;

    xy_scan_gen #(.X_BITS(10), .Y_BITS(10), .LANES(1), .FCNT_BITS(8)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(cont),
        .max_x(max_x), .max_y(max_y), .out_if(if1.master),
        .busy(busy1), .done(done1), .frame_cnt(fcnt1)
    );

    xy_scan_gen #(.X_BITS(10), .Y_BITS(10), .LANES(4), .FCNT_BITS(8)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(cont),
        .max_x(max_x), .max_y(max_y), .out_if(if4.master),
        .busy(busy4), .done(done4), .frame_cnt(fcnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       ready;
        logic       valid;
        logic [9:0] x;
        logic [9:0] y;
        logic       eol;
        logic       eof;
        logic       done;
        logic [7:0] fcnt;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic s, input logic r, input logic v,
                                input logic [9:0] x, input logic [9:0] y,
                                input logic el, input logic ef, input logic d,
                                input logic [7:0] f);
        vec_t t;
        t.start = s; t.ready = r; t.valid = v; t.x = x; t.y = y;
        t.eol = el; t.eof = ef; t.done = d; t.fcnt = f;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are compared at that point too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int bad;
        rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0; ready = 1'b1;
        max_x = '0; max_y = '0;

        // Row k: inputs before edge k, expected outputs after it.
        tbl[0]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 2, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 2, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 2, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 2, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 1, 3, 0, 1, 0, 0, 0);
        tbl[7]  = mk(0, 1, 1, 0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 1, 1, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 1, 2, 1, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 1, 3, 1, 1, 1, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 1, 1);
        tbl[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1);

        // Reset state: latched max_x cleared, so only lane 0 of x=0 is inside.
        step();
        step();
        rst = 1'b0;
        check("rst_valid", if1.out_valid, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_fcnt", fcnt1, 0);
        check("rst_x", if1.out_x, 0);
        check("rst_y", if1.out_y, 0);
        check("rst_mask4", if4.lane_mask, 4'b0001);

        // Basic 4x2 scan with a 3-cycle stall on beat (2,0).
        do_reset();
        max_x = 10'd3; max_y = 10'd1; cont = 1'b0;
        for (int k = 0; k < 13; k++) begin
            start = tbl[k].start;
            ready = tbl[k].ready;
            step();
            check($sformatf("tbl%0d_valid", k), if1.out_valid, tbl[k].valid);
            check($sformatf("tbl%0d_busy", k), busy1, tbl[k].valid);
            check($sformatf("tbl%0d_done", k), done1, tbl[k].done);
            check($sformatf("tbl%0d_fcnt", k), fcnt1, tbl[k].fcnt);
            if (tbl[k].valid) begin
                check($sformatf("tbl%0d_x", k), if1.out_x, tbl[k].x);
                check($sformatf("tbl%0d_y", k), if1.out_y, tbl[k].y);
                check($sformatf("tbl%0d_eol", k), if1.eol, tbl[k].eol);
                check($sformatf("tbl%0d_eof", k), if1.eof, tbl[k].eof);
                check($sformatf("tbl%0d_mask", k), if1.lane_mask, 1);
            end
        end
        start = 1'b0; ready = 1'b1;

        // Four lanes over a 10-pixel line: partial mask on the last beat.
        do_reset();
        max_x = 10'd9; max_y = 10'd0; cont = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("l4_x%0d", k), if4.out_x, 4 * k);
            check($sformatf("l4_mask%0d", k), if4.lane_mask, (k == 2) ? 4'b0011 : 4'b1111);
            check($sformatf("l4_eol%0d", k), if4.eol, k == 2);
            check($sformatf("l4_eof%0d", k), if4.eof, k == 2);
            step();
        end
        check("l4_done", done4, 1);
        check("l4_valid_end", if4.out_valid, 0);
        check("l4_fcnt", fcnt4, 1);
        step();
        check("l4_done_once", done4, 0);

        // Full-width line with four lanes: x must not overflow before eol.
        do_reset();
        max_x = 10'd1023; max_y = 10'd0; cont = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (if4.out_x !== 10'(4 * k) || if4.eol !== (k == 255) || if4.out_valid !== 1'b1) bad++;
            if (k == 255) begin
                check("wide_last_x", if4.out_x, 1020);
                check("wide_last_mask", if4.lane_mask, 4'b1111);
                check("wide_last_eol", if4.eol, 1);
                check("wide_last_eof", if4.eof, 1);
            end
            step();
        end
        check("wide_beat_seq_errs", bad, 0);
        check("wide_done", done4, 1);
        check("wide_fcnt", fcnt4, 1);

        // 1x1 frame, then a start in the done cycle.
        do_reset();
        max_x = 10'd0; max_y = 10'd0; cont = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("p1_x", if1.out_x, 0);
        check("p1_eol", if1.eol, 1);
        check("p1_eof", if1.eof, 1);
        check("p1_mask1", if1.lane_mask, 1);
        check("p1_mask4", if4.lane_mask, 4'b0001);
        step();
        check("p1_done", done1, 1);
        check("p1_valid_end", if1.out_valid, 0);
        check("p1_fcnt", fcnt1, 1);
        start = 1'b1; max_x = 10'd3;
        step();
        start = 1'b0;
        check("restart_valid", if1.out_valid, 1);
        check("restart_done", done1, 0);
        check("restart_fcnt", fcnt1, 0);
        check("restart_eol", if1.eol, 0);

        // Continuous 2x2: start and limit changes in RUN are ignored.
        do_reset();
        max_x = 10'd1; max_y = 10'd1; cont = 1'b1;
        start = 1'b1;
        step();
        max_x = 10'd5; max_y = 10'd5; cont = 1'b0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done1 !== 1'b0) bad++;
        end
        start = 1'b0;
        check("cont_done_pulses", bad, 0);
        check("cont_fcnt", fcnt1, 3);
        check("cont_busy", busy1, 1);
        check("cont_x", if1.out_x, 0);
        check("cont_y", if1.out_y, 0);
        step(); step(); step();
        check("cont_eof_beat", if1.eof, 1);
        check("cont_eof_fcnt", fcnt1, 3);
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        check("abort_eof_valid", if1.out_valid, 0);
        check("abort_eof_busy", busy1, 0);
        check("abort_eof_done", done1, 0);
        check("abort_eof_fcnt", fcnt1, 3);
        abort = 1'b1;
        step();
        check("abort_idle_valid", if1.out_valid, 0);
        check("abort_idle_fcnt", fcnt1, 3);
        start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        check("abort_start_valid", if1.out_valid, 0);
        check("abort_start_fcnt", fcnt1, 3);

        // Abort on the eof beat of a single-frame scan: no done.
        do_reset();
        max_x = 10'd1; max_y = 10'd0; cont = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("abort1_eof_beat", if1.eof, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort1_valid", if1.out_valid, 0);
        check("abort1_done", done1, 0);
        check("abort1_fcnt", fcnt1, 0);
        step();
        check("abort1_done_late", done1, 0);

        // Reset mid-scan wins over start.
        do_reset();
        max_x = 10'd1; max_y = 10'd0; cont = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("mid_fcnt", fcnt1, 2);
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        check("midrst_valid", if1.out_valid, 0);
        check("midrst_busy", busy1, 0);
        check("midrst_done", done1, 0);
        check("midrst_fcnt", fcnt1, 0);
        check("midrst_x", if1.out_x, 0);
        step();
        check("midrst_done_late", done1, 0);
        check("midrst_valid_late", if1.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
